// File: rtl/fetch1_inst_queue.sv
// F1 fetch stage: forwards F0 requests to imem, queues in-order responses for decode, credits stall F0.
// Optional FETCH1_BYPASS_EN: a kept response drives decode directly in its own cycle when the queue is empty.
module fetch1_inst_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redir_i,
    input  logic        f0_valid_i,
    input  logic [63:0] f0_pc_i,
    output logic        stall_f0_o,
    output logic        imem_req_valid_o,
    output logic [63:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_data_i,
    output logic        inst_valid_o,
    output logic [63:0] inst_pc_o,
    output logic [31:0] inst_o,
    input  logic        inst_ready_i
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [63:0]      q_pc_reg   [DEPTH];
    logic [31:0]      q_inst_reg [DEPTH];
    logic [63:0]      pf_pc_reg  [DEPTH];
    logic [PTR_W-1:0] q_wr_ptr_reg, q_rd_ptr_reg, pf_wr_ptr_reg, pf_rd_ptr_reg;
    logic [CNT_W-1:0] occ_reg, outst_reg, drop_reg;
    logic [CNT_W:0]   credits_used;
    logic             fire, resp, resp_drop, resp_keep;
    logic             q_push, q_pop, bypass;
    logic [63:0]      resp_pc;

    assign imem_req_valid_o = f0_valid_i & ~rst;
    assign imem_req_addr_o  = f0_pc_i;
    assign fire             = imem_req_valid_o & imem_req_ready_i;

    // Credits count both queued entries and reads in flight, so the queue can never overflow.
    assign credits_used = {1'b0, occ_reg} + {1'b0, outst_reg};
    assign stall_f0_o   = rst | ~imem_req_ready_i | (credits_used >= (CNT_W+1)'(DEPTH));

    assign resp      = imem_resp_valid_i;
    assign resp_drop = resp & ((drop_reg != '0) | redir_i);
    assign resp_keep = resp & ~resp_drop;
    assign resp_pc   = pf_pc_reg[pf_rd_ptr_reg];

`ifdef FETCH1_BYPASS_EN
    assign bypass       = resp_keep & (occ_reg == '0);
    assign inst_valid_o = ((occ_reg != '0) | bypass) & ~redir_i;
    assign inst_pc_o    = bypass ? resp_pc : q_pc_reg[q_rd_ptr_reg];
    assign inst_o       = bypass ? imem_resp_data_i : q_inst_reg[q_rd_ptr_reg];
`else
    assign bypass       = 1'b0;
    assign inst_valid_o = (occ_reg != '0) & ~redir_i;
    assign inst_pc_o    = q_pc_reg[q_rd_ptr_reg];
    assign inst_o       = q_inst_reg[q_rd_ptr_reg];
`endif

    // A bypassed entry consumed by decode never enters the queue.
    assign q_pop  = (occ_reg != '0) & ~redir_i & inst_ready_i;
    assign q_push = resp_keep & ~(bypass & inst_ready_i);

    always_ff @(posedge clk) begin
        if (q_push) begin
            q_pc_reg[q_wr_ptr_reg]   <= resp_pc;
            q_inst_reg[q_wr_ptr_reg] <= imem_resp_data_i;
        end
        if (fire) begin
            pf_pc_reg[pf_wr_ptr_reg] <= f0_pc_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_wr_ptr_reg  <= '0;
            q_rd_ptr_reg  <= '0;
            pf_wr_ptr_reg <= '0;
            pf_rd_ptr_reg <= '0;
            occ_reg       <= '0;
            outst_reg     <= '0;
            drop_reg      <= '0;
        end else begin
            outst_reg <= outst_reg + CNT_W'(fire) - CNT_W'(resp);
            if (fire) begin
                pf_wr_ptr_reg <= pf_wr_ptr_reg + PTR_W'(1);
            end
            if (redir_i) begin
                // Everything issued before this cycle becomes stale; a request fired now survives.
                q_rd_ptr_reg  <= q_wr_ptr_reg;
                occ_reg       <= '0;
                pf_rd_ptr_reg <= pf_wr_ptr_reg;
                drop_reg      <= outst_reg - CNT_W'(resp);
            end else begin
                if (q_push) begin
                    q_wr_ptr_reg <= q_wr_ptr_reg + PTR_W'(1);
                end
                if (q_pop) begin
                    q_rd_ptr_reg <= q_rd_ptr_reg + PTR_W'(1);
                end
                occ_reg <= occ_reg + CNT_W'(q_push) - CNT_W'(q_pop);
                if (resp_keep) begin
                    pf_rd_ptr_reg <= pf_rd_ptr_reg + PTR_W'(1);
                end
                if (resp_drop && (drop_reg != '0)) begin
                    drop_reg <= drop_reg - CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch1_inst_queue.sv
// Bench for fetch1_inst_queue: scenario tasks checked cycle by cycle against a queue-based reference model.
module tb_fetch1_inst_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        redir_i;
    logic        f0_valid_i;
    logic [63:0] f0_pc_i;
    logic        stall_f0_o;
    logic        imem_req_valid_o;
    logic [63:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_resp_valid_i;
    logic [31:0] imem_resp_data_i;
    logic        inst_valid_o;
    logic [63:0] inst_pc_o;
    logic [31:0] inst_o;
    logic        inst_ready_i;

    always #5 clk = ~clk;

    fetch1_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .redir_i(redir_i),
        .f0_valid_i(f0_valid_i), .f0_pc_i(f0_pc_i), .stall_f0_o(stall_f0_o),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_addr_o(imem_req_addr_o),
        .imem_req_ready_i(imem_req_ready_i), .imem_resp_valid_i(imem_resp_valid_i),
        .imem_resp_data_i(imem_resp_data_i), .inst_valid_o(inst_valid_o),
        .inst_pc_o(inst_pc_o), .inst_o(inst_o), .inst_ready_i(inst_ready_i)
    );

    // In-flight reads (memory side, in order) and decoded-ready entries.
    typedef struct { logic [63:0] pc; logic [31:0] data; int due; bit stale; } rd_t;
    typedef struct { logic [63:0] pc; logic [31:0] data; } ent_t;
    rd_t         mem_q[$];
    ent_t        dq[$];
    logic [63:0] obs[$];
    int          cyc = 0, lat = 1, checks = 0, errors = 0;
    logic [63:0] f0_pc = 64'h0;
    bit          m_fire, m_resp, m_kept, m_byp, m_pop, m_redir;
    logic        exp_stall, exp_valid;
    logic [63:0] exp_pc;
    logic [31:0] exp_inst;

    function automatic logic [31:0] data_of(input logic [63:0] pc);
        return (pc[31:0] * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // F0 honours the stall: valid is only raised when the model says credits and memory are available.
    task automatic set_inputs(input bit want, input bit ready, input bit dready, input bit redir,
                              input logic [63:0] rpc);
        if (redir) f0_pc = rpc;
        m_redir = redir;
        m_resp  = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        m_kept  = m_resp && !mem_q[0].stale && !redir;
`ifdef FETCH1_BYPASS_EN
        m_byp = m_kept && (dq.size() == 0);
`else
        m_byp = 1'b0;
`endif
        exp_stall = !ready || ((dq.size() + mem_q.size()) >= DEPTH);
        m_fire    = want && !exp_stall;
        exp_valid = !redir && ((dq.size() > 0) || m_byp);
        exp_pc    = 64'h0;
        exp_inst  = 32'h0;
        if (dq.size() > 0) begin
            exp_pc   = dq[0].pc;
            exp_inst = dq[0].data;
        end else if (m_byp) begin
            exp_pc   = mem_q[0].pc;
            exp_inst = mem_q[0].data;
        end
        m_pop = exp_valid && dready;
        redir_i           = redir;
        f0_valid_i        = m_fire;
        f0_pc_i           = f0_pc;
        imem_req_ready_i  = ready;
        imem_resp_valid_i = m_resp;
        imem_resp_data_i  = m_resp ? mem_q[0].data : $urandom();
        inst_ready_i      = dready;
    endtask

    task automatic advance();
        rd_t  r;
        ent_t e;
        int   due;
        @(posedge clk);
        r = '{64'h0, 32'h0, 0, 1'b0};
        if (m_resp) r = mem_q.pop_front();
        if (m_pop) begin
            if (dq.size() > 0) e = dq.pop_front();
            else begin
                e.pc   = r.pc;
                e.data = r.data;
            end
            $display("cyc %0d: decode took pc=%h inst=%h", cyc, e.pc, e.data);
        end
        if (m_kept && !(m_byp && m_pop)) begin
            e.pc   = r.pc;
            e.data = r.data;
            dq.push_back(e);
        end
        if (m_redir) begin
            dq.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        end
        if (m_fire) begin
            due = cyc + lat;
            if (mem_q.size() > 0 && mem_q[mem_q.size()-1].due >= due) due = mem_q[mem_q.size()-1].due + 1;
            r.pc = f0_pc; r.data = data_of(f0_pc); r.due = due; r.stale = 1'b0;
            mem_q.push_back(r);
            f0_pc += 64'd4;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; redir_i = 0; f0_valid_i = 0; f0_pc_i = '0; imem_req_ready_i = 1;
        imem_resp_valid_i = 0; imem_resp_data_i = '0; inst_ready_i = 1;
        #3;
        checks++; if (stall_f0_o !== 1'b1) begin errors++; $display("FAIL reset stall: got %b want 1", stall_f0_o); end
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset inst_valid: got %b want 0", inst_valid_o); end
        checks++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset req_valid: got %b want 0", imem_req_valid_o); end
        @(posedge clk); #1;
        set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (stall_f0_o !== exp_stall) begin errors++; $display("FAIL reset release stall: got %b want %b", stall_f0_o, exp_stall); end
        advance();
    endtask

    task automatic test_streaming();
        obs.delete(); f0_pc = 64'h1000; lat = 1;
        for (int c = 0; c < 8; c++) begin
            set_inputs(c < 3, 1'b1, 1'b1, 1'b0, 64'h0);
            @(negedge clk);
            checks++; if (stall_f0_o !== exp_stall) begin errors++; $display("FAIL stream stall @%0d: got %b want %b", cyc, stall_f0_o, exp_stall); end
            checks++; if (imem_req_valid_o !== m_fire || (m_fire && imem_req_addr_o !== f0_pc)) begin errors++; $display("FAIL stream req @%0d: got %b/%h want %b/%h", cyc, imem_req_valid_o, imem_req_addr_o, m_fire, f0_pc); end
            checks++; if (inst_valid_o !== exp_valid) begin errors++; $display("FAIL stream inst_valid @%0d: got %b want %b", cyc, inst_valid_o, exp_valid); end
            if (exp_valid) begin checks++; if (inst_pc_o !== exp_pc || inst_o !== exp_inst) begin errors++; $display("FAIL stream head @%0d: got %h/%h want %h/%h", cyc, inst_pc_o, inst_o, exp_pc, exp_inst); end end
            if (inst_valid_o === 1'b1 && inst_ready_i) obs.push_back(inst_pc_o);
            advance();
        end
        checks++;
        if (obs.size() != 3 || obs[0] !== 64'h1000 || obs[1] !== 64'h1004 || obs[2] !== 64'h1008) begin
            errors++; $display("FAIL stream order: got %0d entries, want 1000,1004,1008", obs.size());
        end
    endtask

    task automatic test_fill();
        f0_pc = 64'h6000; lat = 1;
        for (int c = 0; c < 18; c++) begin
            set_inputs(c < 10, 1'b1, (c == 8) || (c >= 11), 1'b0, 64'h0);
            @(negedge clk);
            checks++; if (stall_f0_o !== exp_stall) begin errors++; $display("FAIL fill stall @%0d: got %b want %b", cyc, stall_f0_o, exp_stall); end
            checks++; if (imem_req_valid_o !== m_fire) begin errors++; $display("FAIL fill req_valid @%0d: got %b want %b", cyc, imem_req_valid_o, m_fire); end
            checks++; if (inst_valid_o !== exp_valid) begin errors++; $display("FAIL fill inst_valid @%0d: got %b want %b", cyc, inst_valid_o, exp_valid); end
            if (exp_valid) begin checks++; if (inst_pc_o !== exp_pc || inst_o !== exp_inst) begin errors++; $display("FAIL fill head @%0d: got %h/%h want %h/%h", cyc, inst_pc_o, inst_o, exp_pc, exp_inst); end end
            advance();
        end
    endtask

    task automatic test_mem_backpressure();
        f0_pc = 64'h2000; lat = 1;
        for (int c = 0; c < 8; c++) begin
            set_inputs(c < 4, c >= 3, 1'b1, 1'b0, 64'h0);
            @(negedge clk);
            checks++; if (stall_f0_o !== exp_stall) begin errors++; $display("FAIL mem_bp stall @%0d: got %b want %b", cyc, stall_f0_o, exp_stall); end
            checks++; if (imem_req_valid_o !== m_fire || imem_req_addr_o !== f0_pc) begin errors++; $display("FAIL mem_bp req @%0d: got %b/%h want %b/%h", cyc, imem_req_valid_o, imem_req_addr_o, m_fire, f0_pc); end
            checks++; if (inst_valid_o !== exp_valid) begin errors++; $display("FAIL mem_bp inst_valid @%0d: got %b want %b", cyc, inst_valid_o, exp_valid); end
            if (exp_valid) begin checks++; if (inst_pc_o !== exp_pc || inst_o !== exp_inst) begin errors++; $display("FAIL mem_bp head @%0d: got %h/%h want %h/%h", cyc, inst_pc_o, inst_o, exp_pc, exp_inst); end end
            advance();
        end
    endtask

    task automatic test_redirect();
        obs.delete(); f0_pc = 64'h3000;
        for (int c = 0; c < 18; c++) begin
            lat = (c < 2) ? 1 : 3;
            set_inputs((c == 0) || (c == 2) || (c == 3) || (c >= 4 && c < 8), 1'b1, c >= 4, c == 4, 64'h8000);
            @(negedge clk);
            checks++; if (stall_f0_o !== exp_stall) begin errors++; $display("FAIL redir stall @%0d: got %b want %b", cyc, stall_f0_o, exp_stall); end
            checks++; if (imem_req_valid_o !== m_fire || (m_fire && imem_req_addr_o !== f0_pc)) begin errors++; $display("FAIL redir req @%0d: got %b/%h want %b/%h", cyc, imem_req_valid_o, imem_req_addr_o, m_fire, f0_pc); end
            checks++; if (inst_valid_o !== exp_valid) begin errors++; $display("FAIL redir inst_valid @%0d: got %b want %b", cyc, inst_valid_o, exp_valid); end
            if (exp_valid) begin checks++; if (inst_pc_o !== exp_pc || inst_o !== exp_inst) begin errors++; $display("FAIL redir head @%0d: got %h/%h want %h/%h", cyc, inst_pc_o, inst_o, exp_pc, exp_inst); end end
            if (inst_valid_o === 1'b1 && inst_ready_i) obs.push_back(inst_pc_o);
            advance();
        end
        checks++;
        if (obs.size() != 4 || obs[0] !== 64'h8000) begin
            errors++; $display("FAIL redir first_pc: got %0d entries first %h, want 4 entries first 8000", obs.size(), (obs.size() > 0) ? obs[0] : 64'h0);
        end
    endtask

    task automatic test_random();
        logic [63:0] rpc;
        for (int c = 0; c < 600; c++) begin
            lat = $urandom_range(1, 4);
            rpc = 64'h9000 + 64'({$urandom_range(0, 255), 2'b00});
            set_inputs($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6,
                       $urandom_range(0, 39) == 0, rpc);
            @(negedge clk);
            checks++; if (stall_f0_o !== exp_stall) begin errors++; $display("FAIL random stall @%0d: got %b want %b", cyc, stall_f0_o, exp_stall); end
            checks++; if (imem_req_valid_o !== m_fire || (m_fire && imem_req_addr_o !== f0_pc)) begin errors++; $display("FAIL random req @%0d: got %b/%h want %b/%h", cyc, imem_req_valid_o, imem_req_addr_o, m_fire, f0_pc); end
            checks++; if (inst_valid_o !== exp_valid) begin errors++; $display("FAIL random inst_valid @%0d: got %b want %b", cyc, inst_valid_o, exp_valid); end
            if (exp_valid) begin checks++; if (inst_pc_o !== exp_pc || inst_o !== exp_inst) begin errors++; $display("FAIL random head @%0d: got %h/%h want %h/%h", cyc, inst_pc_o, inst_o, exp_pc, exp_inst); end end
            advance();
        end
        // Let everything drain so the next scenario starts from an empty block.
        for (int c = 0; c < 20; c++) begin
            set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
            advance();
        end
    endtask

    task automatic test_reset_midstream();
        f0_pc = 64'h4000;
        for (int c = 0; c < 4; c++) begin
            lat = (c < 3) ? 1 : 4;
            set_inputs(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
            @(negedge clk);
            checks++; if (stall_f0_o !== exp_stall) begin errors++; $display("FAIL mid_rst fill stall @%0d: got %b want %b", cyc, stall_f0_o, exp_stall); end
            checks++; if (inst_valid_o !== exp_valid) begin errors++; $display("FAIL mid_rst fill inst_valid @%0d: got %b want %b", cyc, inst_valid_o, exp_valid); end
            advance();
        end
        // Three entries queued and one read in flight: assert reset between clock edges.
        set_inputs(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
        #2; rst = 1'b1; #1;
        checks++; if (stall_f0_o !== 1'b1) begin errors++; $display("FAIL mid_rst stall: got %b want 1", stall_f0_o); end
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst inst_valid: got %b want 0", inst_valid_o); end
        checks++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst req_valid: got %b want 0", imem_req_valid_o); end
        @(posedge clk); #1;
        mem_q.delete(); dq.delete(); obs.delete();
        f0_pc = 64'h5000; lat = 2;
        set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            set_inputs((c >= 1) && (c < 3), 1'b1, 1'b1, 1'b0, 64'h0);
            @(negedge clk);
            checks++; if (stall_f0_o !== exp_stall) begin errors++; $display("FAIL mid_rst stall @%0d: got %b want %b", cyc, stall_f0_o, exp_stall); end
            checks++; if (inst_valid_o !== exp_valid) begin errors++; $display("FAIL mid_rst inst_valid @%0d: got %b want %b", cyc, inst_valid_o, exp_valid); end
            if (exp_valid) begin checks++; if (inst_pc_o !== exp_pc || inst_o !== exp_inst) begin errors++; $display("FAIL mid_rst head @%0d: got %h/%h want %h/%h", cyc, inst_pc_o, inst_o, exp_pc, exp_inst); end end
            if (inst_valid_o === 1'b1 && inst_ready_i) obs.push_back(inst_pc_o);
            advance();
        end
        checks++;
        if (obs.size() != 2 || obs[0] !== 64'h5000) begin
            errors++; $display("FAIL mid_rst first_pc: got %0d entries first %h, want 2 entries first 5000", obs.size(), (obs.size() > 0) ? obs[0] : 64'h0);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_fill();
        test_mem_backpressure();
        test_redirect();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch1_inst_queue.md
Name: fetch1_inst_queue

Overview:
- Receiving end of the F0 fetch interface. Takes the F0 valid/PC pair each cycle and issues it as an instruction-memory read.
- Collects the in-order read responses into a small instruction queue that feeds decode.
- Produces the stall back to F0 using credit-based flow control.
- Handles a writeback redirect by flushing the queue and discarding responses that are still in flight.

Parameters:
- DEPTH, 4, queue entries; power of 2, at least 2. It also bounds outstanding reads.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy, outstanding and drop counters.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- redir_i  input  1  writeback redirect; flushes the block
- f0_valid_i  input  1  F0 request valid
- f0_pc_i  input  64  F0 request PC
- stall_f0_o  output  1  stall to F0; F0 holds its PC and drops valid while this is high
- imem_req_valid_o  output  1  memory read request valid
- imem_req_addr_o  output  64  memory read address
- imem_req_ready_i  input  1  memory accepts the request this cycle
- imem_resp_valid_i  input  1  read response valid; responses arrive in order, at least 1 cycle after acceptance
- imem_resp_data_i  input  32  instruction word
- inst_valid_o  output  1  queue head valid to decode
- inst_pc_o  output  64  PC of the head entry
- inst_o  output  32  instruction of the head entry
- inst_ready_i  input  1  decode consumes the head entry

Behaviour:
- Reset:
  - Queue empty; pointers, occ, outst and drop all 0.
  - inst_valid_o=0, imem_req_valid_o=0, stall_f0_o=1. Stall stays high only while rst is high.
- Request path (combinational):
  - imem_req_valid_o = f0_valid_i.
  - imem_req_addr_o = f0_pc_i.
  - fire = f0_valid_i & imem_req_ready_i.
  - When fire is high, push f0_pc_i into a PC FIFO of DEPTH entries that tracks the outstanding reads.
- Stall (combinational): stall_f0_o = !imem_req_ready_i | ((occ + outst) >= DEPTH).
  - occ and outst are registered values.
  - Because of this rule, the queue can never overflow.
  - A pop in the current cycle does not release a credit until the next cycle.
- Response path:
  - A response is dropped when drop != 0 or redir_i is high; a dropped response decrements drop (saturating at 0) and does nothing else.
  - A response that is not dropped pops the PC FIFO head and writes {pc, data} into the queue at the write pointer.
- Outstanding count: outst_next = outst + fire - resp. This holds for both kept and dropped responses.
- Redirect (redir_i=1 in cycle T):
  - At the edge ending T, the queue is emptied (occ=0, pointers equal) and the PC FIFO is cleared.
  - drop <= outst - resp_T, so every read issued before T is discarded.
  - A request fired in T uses the redirected PC. It is counted in outst and its PC is pushed into the cleared PC FIFO, so it survives the flush.
  - inst_valid_o is forced to 0 during T.
  - A decode pop in T is ignored.
- Decode handshake:
  - inst_valid_o = (occ != 0) & !redir_i.
  - Pop when inst_valid_o & inst_ready_i.
  - Push and pop may happen in the same cycle; occ then stays the same.
  - Pointers wrap modulo DEPTH.
- Latency: a response in cycle N is visible at inst_valid_o in cycle N+1.
- Ordering: queue output order equals issue order.
- No memory-side backpressure on responses is needed, because credits reserve the space.

Optional Feature:
- Macro: FETCH1_BYPASS_EN.
- Defined:
  - If occ==0, a response that is not dropped and is not in a redirect cycle drives inst_valid_o/inst_pc_o/inst_o in the same cycle.
  - If inst_ready_i is high in that cycle, the entry is consumed and never written; otherwise it is written to the queue as normal.
  - Latency becomes 0 when the queue is empty.
- Undefined: 1-cycle latency as above; no combinational path from imem_resp_* to inst_*.

Test Plan:
- Streaming: F0 issues PCs 0x1000, 0x1004, 0x1008; memory has 1-cycle latency, always ready; decode always ready -> decode sees (0x1000,I0), (0x1004,I1), (0x1008,I2) in order, 1 cycle after each response; stall_f0_o stays 0.
- Fill: decode not ready, DEPTH=4 -> after 4 accepted requests stall_f0_o=1 and imem_req_valid_o=0; one decode pop -> stall drops 1 cycle later.
- Memory backpressure: imem_req_ready_i=0 for 3 cycles -> stall_f0_o=1 in those cycles, no FIFO push, PC held at 0x2000, issued once ready returns.
- Redirect with 2 in flight: latency 3, redir_i to 0x8000 -> both stale responses dropped (drop goes 2->0); the queue shows only 0x8000 and later entries; a pop during the redirect cycle has no effect.
- Reset mid-stream: assert rst asynchronously with occ=3, outst=1 -> all outputs reach reset values immediately; after release the first response maps to the first post-reset PC.
- Bypass (FETCH1_BYPASS_EN): queue empty, response at cycle N with inst_ready_i=1 -> inst_valid_o=1 in cycle N and occ stays 0.
